mult_div_unit: RTL

//  Multicycle signed multiply/divide responder for the MIPS datapath; owns the HI and LO registers.
//  The control FSM issues a one-cycle start with MDcontrol and waits for done or Div0.

---
 rtl/mult_div_if.sv | 25 ++
 rtl/mult_div_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mult_div_if.sv
// Handshake and result bus between the control FSM and the multiply/divide unit.
// The unit drives busy/done/Div0/HI/LO; the requester drives start/MDcontrol/A/B.
interface mult_div_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             MDcontrol;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             Div0;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, MDcontrol, A, B,
        input  busy, done, Div0, HI, LO
    );

    modport slave (
        input  start, MDcontrol, A, B,
        output busy, done, Div0, HI, LO
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit owning HI and LO.
// One iteration per cycle; results land in HI/LO on the same edge that raises done.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic       clock,
    input logic       reset,
    mult_div_if.slave bus
);
    localparam int unsigned ACC_W = 2 * WIDTH + 2;

    typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             op_div;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH:0]   mcand;
    logic [ACC_W-1:0] acc;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;

    logic [WIDTH:0]   booth_upper_c;
    logic [ACC_W-1:0] acc_next_c;
    logic [WIDTH:0]   shifted_c;
    logic [WIDTH:0]   diff_c;
    logic             fits_c;
    logic [WIDTH-1:0] rem_next_c;
    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic [WIDTH-1:0] q_fix_c;
    logic [WIDTH-1:0] r_fix_c;
    logic             last_step_c;

    // Booth step: upper half is one bit wider so subtracting the most negative multiplicand cannot overflow.
    always_comb begin
        booth_upper_c = acc[ACC_W-1:WIDTH+1];
        case (acc[1:0])
            2'b01:   booth_upper_c = booth_upper_c + mcand;
            2'b10:   booth_upper_c = booth_upper_c - mcand;
            default: booth_upper_c = acc[ACC_W-1:WIDTH+1];
        endcase
        acc_next_c = ACC_W'($signed({booth_upper_c, acc[WIDTH:0]}) >>> 1);
    end

    // Restoring division step on magnitudes.
    always_comb begin
        shifted_c  = {rem, quo[WIDTH-1]};
        diff_c     = shifted_c - {1'b0, dvs};
        fits_c     = (shifted_c >= {1'b0, dvs});
        rem_next_c = fits_c ? WIDTH'(diff_c) : WIDTH'(shifted_c);
    end

    // Operand magnitudes at issue, and sign correction of the division result.
    always_comb begin
        a_mag_c     = bus.A[WIDTH-1] ? (~bus.A + WIDTH'(1)) : bus.A;
        b_mag_c     = bus.B[WIDTH-1] ? (~bus.B + WIDTH'(1)) : bus.B;
        q_fix_c     = (a_neg ^ b_neg) ? (~quo + WIDTH'(1)) : quo;
        r_fix_c     = a_neg ? (~rem + WIDTH'(1)) : rem;
        last_step_c = (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            op_div   <= 1'b0;
            a_neg    <= 1'b0;
            b_neg    <= 1'b0;
            mcand    <= '0;
            acc      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.Div0 <= 1'b0;
            bus.HI   <= '0;
            bus.LO   <= '0;
        end else begin
            bus.done <= 1'b0;
            bus.Div0 <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt <= '0;
                        if (!bus.MDcontrol) begin
                            op_div   <= 1'b0;
                            mcand    <= {bus.A[WIDTH-1], bus.A};
                            acc      <= {{(WIDTH + 1){1'b0}}, bus.B, 1'b0};
                            bus.busy <= 1'b1;
                            state    <= MULT;
                        end else if (bus.B == '0) begin
                            bus.Div0 <= 1'b1;
                        end else begin
                            op_div   <= 1'b1;
                            a_neg    <= bus.A[WIDTH-1];
                            b_neg    <= bus.B[WIDTH-1];
                            rem      <= '0;
                            quo      <= a_mag_c;
                            dvs      <= b_mag_c;
                            bus.busy <= 1'b1;
                            state    <= DIV;
                        end
                    end
                end
                MULT: begin
                    acc <= acc_next_c;
                    cnt <= cnt + CNT_W'(1);
                    if (last_step_c) state <= FIX;
                end
                DIV: begin
                    rem <= rem_next_c;
                    quo <= {quo[WIDTH-2:0], fits_c};
                    cnt <= cnt + CNT_W'(1);
                    if (last_step_c) state <= FIX;
                end
                FIX: begin
                    if (op_div) begin
                        bus.HI <= r_fix_c;
                        bus.LO <= q_fix_c;
                    end else begin
                        bus.HI <= acc[2*WIDTH:WIDTH+1];
                        bus.LO <= acc[WIDTH:1];
                    end
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
